// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
//   ldr_state_t : loader FSM state encoding
//   HDR_BYTES   : length-prefix size in bytes (big-endian)
//   IMEM_BASE   : default first byte address of the instruction memory
//   lane_strb() : one-hot strobe bit for a byte lane (lane 0 = wstrb[3])
package imem_pkg;

  typedef enum logic [2:0] {IDLE, HDR, LOAD, DONE, ERR} ldr_state_t;

  localparam int          HDR_BYTES = 4;
  localparam logic [31:0] IMEM_BASE = 32'hBFC00000;

  function automatic logic [3:0] lane_strb(input logic [1:0] lane);
    return 4'b1000 >> lane;
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the boot loader.
//   s_data/s_valid/s_ready : byte stream, transfer when s_valid && s_ready
//   mem_we/mem_addr/mem_wdata/mem_wstrb : one-cycle word write strobe
// modport slave  : the loader (stream sink, memory writer)
// modport master : the environment (stream source, memory)
interface imem_loader_if #(
  parameter int A_WIDTH = 32
);
  logic [7:0]         s_data;
  logic               s_valid;
  logic               s_ready;
  logic               mem_we;
  logic [A_WIDTH-1:0] mem_addr;
  logic [31:0]        mem_wdata;
  logic [3:0]         mem_wstrb;

  modport slave (
    input  s_data, s_valid,
    output s_ready, mem_we, mem_addr, mem_wdata, mem_wstrb
  );

  modport master (
    output s_data, s_valid,
    input  s_ready, mem_we, mem_addr, mem_wdata, mem_wstrb
  );
endinterface

// File: rtl/imem_loader_packer.sv
// imem_word_packer: gathers payload bytes into a 32-bit word (lane 0 is the
// lowest address and lands in bits [31:24]) and issues one registered write
// when lane 3 fills or the last payload byte arrives.
//   clk, rst_n : clock, async active-low reset
//   clr        : drop any partially gathered word (new load starting)
//   push       : accept din into byte lane `lane`
//   last       : this push is the final payload byte
//   addr       : word-aligned address of the word being gathered
//   we/waddr/wdata/wstrb : registered write port, held when we=0
module imem_word_packer
  import imem_pkg::*;
#(
  parameter int                 A_WIDTH   = 32,
  parameter logic [A_WIDTH-1:0] BASE_ADDR = A_WIDTH'(IMEM_BASE)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               push,
  input  logic               last,
  input  logic [1:0]         lane,
  input  logic [7:0]         din,
  input  logic [A_WIDTH-1:0] addr,
  output logic               we,
  output logic [A_WIDTH-1:0] waddr,
  output logic [31:0]        wdata,
  output logic [3:0]         wstrb
);

  logic [31:0] lanes_q;
  logic [3:0]  strb_q;
  logic [31:0] word_nxt;
  logic [3:0]  strb_nxt;
  logic        flush;

  // Merge the incoming byte into the partial word so a flush can write the
  // complete word in the same edge that accepts its final byte.
  always_comb begin
    word_nxt = lanes_q;
    case (lane)
      2'd0:    word_nxt[31:24] = din;
      2'd1:    word_nxt[23:16] = din;
      2'd2:    word_nxt[15:8]  = din;
      default: word_nxt[7:0]   = din;
    endcase
    strb_nxt = strb_q | lane_strb(lane);
    flush    = (lane == 2'd3) || last;
  end

  // Lanes fill in order, so a partial final word naturally carries leading
  // strobe ones and zeros in its unfilled lanes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we      <= 1'b0;
      waddr   <= BASE_ADDR;
      wdata   <= '0;
      wstrb   <= '0;
      lanes_q <= '0;
      strb_q  <= '0;
    end else begin
      we <= 1'b0;
      if (clr) begin
        lanes_q <= '0;
        strb_q  <= '0;
      end else if (push) begin
        if (flush) begin
          we      <= 1'b1;
          waddr   <= addr;
          wdata   <= word_nxt;
          wstrb   <= strb_nxt;
          lanes_q <= '0;
          strb_q  <= '0;
        end else begin
          lanes_q <= word_nxt;
          strb_q  <= strb_nxt;
        end
      end
    end
  end

endmodule

// File: rtl/imem_loader.sv
// imem_loader: boot-time writer for the instruction memory. Takes a stream of
// a 4-byte big-endian length followed by that many payload bytes, packs them
// into words and writes them upward from BASE_ADDR, holding the CPU in reset
// until the image is complete.
//   clk, rst_n   : clock, async active-low reset
//   start        : one-cycle pulse, begin a load (honoured in IDLE/DONE/ERR)
//   bus          : byte stream in, memory write port out
//   busy         : collecting header or payload
//   done         : image fully written
//   err          : header length larger than the memory
//   bytes_loaded : payload bytes accepted in the current load
//   cpu_rst_n    : CPU reset release, high only once the image is written
module imem_loader
  import imem_pkg::*;
#(
  parameter int                 A_WIDTH     = 32,
  parameter logic [A_WIDTH-1:0] BASE_ADDR   = A_WIDTH'(IMEM_BASE),
  parameter int                 DEPTH_BYTES = 4096,
  localparam int                BL_W        = $clog2(DEPTH_BYTES) + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  imem_loader_if.slave    bus,
  output logic            busy,
  output logic            done,
  output logic            err,
  output logic [BL_W-1:0] bytes_loaded,
  output logic            cpu_rst_n
);

  localparam logic [31:0] DEPTH_W  = 32'(DEPTH_BYTES);
  localparam logic [1:0]  HDR_LAST = 2'(HDR_BYTES - 1);

  ldr_state_t         state;
  logic               s_ready_q;
  logic [23:0]        len_q;
  logic [1:0]         hdr_cnt;
  logic [31:0]        hdr_nxt;
  logic               accept;
  logic               restart;
  logic               last_byte;
  logic [A_WIDTH-1:0] word_addr;

  logic               pk_we;
  logic [A_WIDTH-1:0] pk_addr;
  logic [31:0]        pk_wdata;
  logic [3:0]         pk_wstrb;

  assign accept  = bus.s_valid && s_ready_q;
  assign restart = start && (state inside {IDLE, DONE, ERR});
  // Only the low 24 bits of the length are kept: the full 32-bit value is
  // judged on the 4th header byte, and anything surviving fits in BL_W.
  assign hdr_nxt   = {len_q, bus.s_data};
  assign last_byte = (bytes_loaded == len_q[BL_W-1:0] - BL_W'(1));
  assign word_addr = BASE_ADDR + A_WIDTH'({bytes_loaded[BL_W-1:2], 2'b00});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      s_ready_q    <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      cpu_rst_n    <= 1'b0;
      bytes_loaded <= '0;
      len_q        <= '0;
      hdr_cnt      <= '0;
    end else begin
      case (state)
        IDLE, DONE, ERR: begin
          if (start) begin
            state        <= HDR;
            s_ready_q    <= 1'b1;
            busy         <= 1'b1;
            done         <= 1'b0;
            err          <= 1'b0;
            cpu_rst_n    <= 1'b0;
            bytes_loaded <= '0;
            len_q        <= '0;
            hdr_cnt      <= '0;
          end
        end
        HDR: begin
          if (accept) begin
            len_q   <= hdr_nxt[23:0];
            hdr_cnt <= hdr_cnt + 2'd1;
            if (hdr_cnt == HDR_LAST) begin
              if (hdr_nxt == 32'd0) begin
                state     <= DONE;
                s_ready_q <= 1'b0;
                busy      <= 1'b0;
                done      <= 1'b1;
                cpu_rst_n <= 1'b1;
              end else if (hdr_nxt > DEPTH_W) begin
                state     <= ERR;
                s_ready_q <= 1'b0;
                busy      <= 1'b0;
                err       <= 1'b1;
              end else begin
                state <= LOAD;
              end
            end
          end
        end
        LOAD: begin
          if (accept) begin
            bytes_loaded <= bytes_loaded + BL_W'(1);
            // The packer's final write pulses in the first DONE cycle.
            if (last_byte) begin
              state     <= DONE;
              s_ready_q <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
              cpu_rst_n <= 1'b1;
            end
          end
        end
        default: begin
          state     <= IDLE;
          s_ready_q <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

  imem_word_packer #(
    .A_WIDTH  (A_WIDTH),
    .BASE_ADDR(BASE_ADDR)
  ) u_packer (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (restart),
    .push (accept && (state == LOAD)),
    .last (last_byte),
    .lane (bytes_loaded[1:0]),
    .din  (bus.s_data),
    .addr (word_addr),
    .we   (pk_we),
    .waddr(pk_addr),
    .wdata(pk_wdata),
    .wstrb(pk_wstrb)
  );

  assign bus.s_ready   = s_ready_q;
  assign bus.mem_we    = pk_we;
  assign bus.mem_addr  = pk_addr;
  assign bus.mem_wdata = pk_wdata;
  assign bus.mem_wstrb = pk_wstrb;

endmodule

// File: tb/tb_imem_loader.sv
// Testbench for imem_loader: directed load sequences with a write scoreboard.
module tb_imem_loader;

  localparam int BL_W = 13;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } wr_t;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            start;
  logic            busy;
  logic            done;
  logic            err;
  logic            cpu_rst_n;
  logic [BL_W-1:0] bytes_loaded;

  int   checks   = 0;
  int   failures = 0;
  wr_t  exp_q[$];
  logic [7:0] payload[$];

  imem_loader_if #(.A_WIDTH(32)) bus ();

  imem_loader #(
    .A_WIDTH    (32),
    .BASE_ADDR  (32'hBFC00000),
    .DEPTH_BYTES(4096)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .bus         (bus),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .bytes_loaded(bytes_loaded),
    .cpu_rst_n   (cpu_rst_n)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Scoreboard: every write pulse is matched against the oldest expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.mem_we === 1'b1) begin
      checks++;
      assert (exp_q.size() > 0) else begin
        failures++;
        $error("FAIL unexpected_write observed addr=%0h data=%0h expected none",
               bus.mem_addr, bus.mem_wdata);
      end
      if (exp_q.size() > 0) begin
        wr_t e;
        e = exp_q.pop_front();
        chk("wr_addr", bus.mem_addr, e.addr);
        chk("wr_data", bus.mem_wdata, e.data);
        chk("wr_strb", bus.mem_wstrb, e.strb);
      end
    end
  end

  // Reference packing of the payload into expected word writes.
  task automatic push_expected();
    int n = payload.size();
    for (int w = 0; w * 4 < n; w++) begin
      wr_t e;
      e.addr = 32'hBFC00000 + 32'(w * 4);
      e.data = '0;
      e.strb = '0;
      for (int j = 0; j < 4; j++) begin
        if (w * 4 + j < n) begin
          e.data[31 - 8 * j -: 8] = payload[w * 4 + j];
          e.strb[3 - j]           = 1'b1;
        end
      end
      exp_q.push_back(e);
    end
  endtask

  // All tasks start and end at a falling edge.
  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic put_byte(input logic [7:0] b);
    int n = 0;
    bus.s_data  = b;
    bus.s_valid = 1'b1;
    while (bus.s_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("s_ready_timeout", bus.s_ready, 1);
    @(negedge clk);
    bus.s_valid = 1'b0;
  endtask

  task automatic send_header(input logic [31:0] len);
    put_byte(len[31:24]);
    put_byte(len[23:16]);
    put_byte(len[15:8]);
    put_byte(len[7:0]);
  endtask

  task automatic send_payload(input int gap_max, input bit start_mid);
    for (int i = 0; i < payload.size(); i++) begin
      if (gap_max > 0) begin
        int g = $urandom_range(0, gap_max);
        repeat (g) begin
          start = start_mid && ($urandom_range(0, 2) == 0);
          @(negedge clk);
          start = 1'b0;
        end
      end
      put_byte(payload[i]);
      if (start_mid && i == 5) pulse_start();
    end
  endtask

  task automatic drain(input string tag);
    @(negedge clk);
    @(negedge clk);
    chk(tag, exp_q.size(), 0);
  endtask

  initial begin
    rst_n       = 1'b0;
    start       = 1'b0;
    bus.s_data  = 8'h00;
    bus.s_valid = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state
    chk("rst_s_ready", bus.s_ready, 0);
    chk("rst_mem_we", bus.mem_we, 0);
    chk("rst_mem_addr", bus.mem_addr, 32'hBFC00000);
    chk("rst_mem_wdata", bus.mem_wdata, 0);
    chk("rst_mem_wstrb", bus.mem_wstrb, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_bytes", bytes_loaded, 0);
    chk("rst_cpu_rst_n", cpu_rst_n, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Test 1: start together with s_valid -> byte not taken, then 8-byte image
    bus.s_data  = 8'h55;
    bus.s_valid = 1'b1;
    pulse_start();
    bus.s_valid = 1'b0;
    chk("t1_busy", busy, 1);
    chk("t1_s_ready", bus.s_ready, 1);
    exp_q.push_back('{32'hBFC00000, 32'h13000000, 4'hF});
    exp_q.push_back('{32'hBFC00004, 32'h93001000, 4'hF});
    send_header(32'd8);
    payload = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    send_payload(0, 0);
    chk("t1_done", done, 1);
    chk("t1_cpu_rst_n", cpu_rst_n, 1);
    chk("t1_s_ready_done", bus.s_ready, 0);
    chk("t1_busy_done", busy, 0);
    chk("t1_bytes", bytes_loaded, 8);
    drain("t1_queue_empty");

    // Test 2: partial final word
    pulse_start();
    chk("t2_done_cleared", done, 0);
    chk("t2_cpu_rst_n_low", cpu_rst_n, 0);
    exp_q.push_back('{32'hBFC00000, 32'hAABBCCDD, 4'hF});
    exp_q.push_back('{32'hBFC00004, 32'hEEFF0000, 4'hC});
    send_header(32'd6);
    payload = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF};
    send_payload(0, 0);
    chk("t2_bytes", bytes_loaded, 6);
    chk("t2_done", done, 1);
    drain("t2_queue_empty");

    // Test 3: oversize header -> ERR, then restart
    pulse_start();
    send_header(32'h00001001);
    chk("t3_err", err, 1);
    chk("t3_s_ready", bus.s_ready, 0);
    chk("t3_cpu_rst_n", cpu_rst_n, 0);
    chk("t3_done", done, 0);
    repeat (3) @(negedge clk);
    chk("t3_err_hold", err, 1);
    pulse_start();
    chk("t3_err_cleared", err, 0);
    chk("t3_busy_hdr", busy, 1);
    chk("t3_s_ready_hdr", bus.s_ready, 1);
    send_header(32'd0);
    chk("t3_done_len0", done, 1);
    drain("t3_queue_empty");

    // Test 4: len=12 with random gaps and ignored start pulses
    pulse_start();
    payload = '{8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB,
                8'hCD, 8'hEF, 8'hF0, 8'h0D, 8'hBE, 8'hEF};
    push_expected();
    send_header(32'd12);
    send_payload(3, 1);
    chk("t4_bytes", bytes_loaded, 12);
    chk("t4_done", done, 1);
    chk("t4_cpu_rst_n", cpu_rst_n, 1);
    drain("t4_queue_empty");

    // Test 5: async reset after 5 payload bytes, then clean reload
    pulse_start();
    payload = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    push_expected();
    void'(exp_q.pop_back());
    send_header(32'd8);
    send_payload(0, 0);
    chk("t5_bytes_before_rst", bytes_loaded, 5);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_s_ready", bus.s_ready, 0);
    chk("t5_rst_mem_we", bus.mem_we, 0);
    chk("t5_rst_mem_addr", bus.mem_addr, 32'hBFC00000);
    chk("t5_rst_mem_wdata", bus.mem_wdata, 0);
    chk("t5_rst_mem_wstrb", bus.mem_wstrb, 0);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_bytes", bytes_loaded, 0);
    chk("t5_rst_cpu_rst_n", cpu_rst_n, 0);
    chk("t5_queue_empty_rst", exp_q.size(), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    pulse_start();
    payload = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5, 8'hF6, 8'h07};
    push_expected();
    send_header(32'd7);
    send_payload(0, 0);
    chk("t5_done", done, 1);
    chk("t5_bytes", bytes_loaded, 7);
    drain("t5_queue_empty");

    // Test 6: len=0 -> DONE without writes, then reload
    pulse_start();
    send_header(32'd0);
    chk("t6_done", done, 1);
    chk("t6_cpu_rst_n", cpu_rst_n, 1);
    chk("t6_bytes", bytes_loaded, 0);
    @(negedge clk);
    pulse_start();
    chk("t6_done_cleared", done, 0);
    payload = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    push_expected();
    send_header(32'd4);
    send_payload(0, 0);
    chk("t6_reload_done", done, 1);
    chk("t6_reload_bytes", bytes_loaded, 4);
    drain("t6_queue_empty");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
